// File: rtl/universal_ff_bank.sv
// universal_ff_bank
//   WIDTH-bit register bank. Each bit behaves as a D, T, JK or SR flip-flop,
//   chosen at runtime by mode (same mode for every bit). It also provides a
//   sticky flag that records SR=11, and a registered mask of changed bits.
// Parameters
//   WIDTH      number of bits (>=1)
//   RESET_VAL  value of q while rst is high
//   SR_POLICY  action for s=r=1 in SR mode: 0 hold, 1 set, 2 reset; any other value means hold
// Ports
//   clk      rising-edge clock
//   rst      asynchronous, active-high reset
//   en       update enable; when low every bit holds
//   mode     00 D, 01 T, 10 JK, 11 SR
//   a        d / t / j / s
//   b        ignored / ignored / k / r
//   err_clr  clears sr_err (a set in the same cycle wins)
//   q        register state
//   qb       ~q, combinational
//   sr_err   sticky: an SR=11 condition was applied
//   chg      mask of the bits that changed on the last edge
module universal_ff_bank #(
  parameter int unsigned       WIDTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter int unsigned       SR_POLICY = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             sr_err,
  output logic [WIDTH-1:0] chg
);

  localparam logic [1:0] MODE_D  = 2'b00;
  localparam logic [1:0] MODE_T  = 2'b01;
  localparam logic [1:0] MODE_JK = 2'b10;
  localparam logic [1:0] MODE_SR = 2'b11;

  logic [WIDTH-1:0] q_next;
  logic             sr_hit;

  // Next-state computation for each bit, and detection of SR=11.
  always_comb begin
    q_next = q;
    sr_hit = 1'b0;
    if (en) begin
      case (mode)
        MODE_D: q_next = a;
        MODE_T: q_next = q ^ a;
        MODE_JK: begin
          for (int i = 0; i < int'(WIDTH); i++) begin
            case ({a[i], b[i]})
              2'b01:   q_next[i] = 1'b0;
              2'b10:   q_next[i] = 1'b1;
              2'b11:   q_next[i] = ~q[i];
              default: q_next[i] = q[i];
            endcase
          end
        end
        MODE_SR: begin
          sr_hit = |(a & b);
          for (int i = 0; i < int'(WIDTH); i++) begin
            case ({a[i], b[i]})
              2'b01: q_next[i] = 1'b0;
              2'b10: q_next[i] = 1'b1;
              2'b11: begin
                // Any policy value that is not recognised falls back to hold.
                if (SR_POLICY == 1)      q_next[i] = 1'b1;
                else if (SR_POLICY == 2) q_next[i] = 1'b0;
                else                     q_next[i] = q[i];
              end
              default: q_next[i] = q[i];
            endcase
          end
        end
        default: q_next = q;
      endcase
    end
  end

  // State, change mask and sticky error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q      <= RESET_VAL;
      chg    <= '0;
      sr_err <= 1'b0;
    end else begin
      q   <= q_next;
      chg <= q_next ^ q;
      if (sr_hit)       sr_err <= 1'b1;
      else if (err_clr) sr_err <= 1'b0;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_universal_ff_bank.sv
// Directed bench for universal_ff_bank. It drives three instances from the same
// stimulus: SR_POLICY 0, 1 and 2. The third instance also has a nonzero RESET_VAL.
module tb_universal_ff_bank;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         err_clr;

  logic [W-1:0] q0, qb0, chg0, q1, qb1, chg1, q2, qb2, chg2;
  logic         e0, e1, e2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  universal_ff_bank #(.WIDTH(W), .RESET_VAL(8'h00), .SR_POLICY(0)) dut0 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q0), .qb(qb0), .sr_err(e0), .chg(chg0));
  universal_ff_bank #(.WIDTH(W), .RESET_VAL(8'h00), .SR_POLICY(1)) dut1 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q1), .qb(qb1), .sr_err(e1), .chg(chg1));
  universal_ff_bank #(.WIDTH(W), .RESET_VAL(8'h81), .SR_POLICY(2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
    .q(q2), .qb(qb2), .sr_err(e2), .chg(chg2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [1:0] m, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic ec);
    en = e; mode = m; a = av; b = bv; err_clr = ec;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    #3;
    // Reset state, before any clock edge.
    check("rst_q0",   32'(q0),   32'h00);
    check("rst_qb0",  32'(qb0),  32'hFF);
    check("rst_chg0", 32'(chg0), 32'h00);
    check("rst_err0", 32'(e0),   32'h0);
    check("rst_q2",   32'(q2),   32'h81);
    check("rst_qb2",  32'(qb2),  32'h7E);
    @(negedge clk);
    rst = 1'b0;

    // D mode
    drive(1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
    edge_step();
    check("d_q0",   32'(q0),   32'hA5);
    check("d_qb0",  32'(qb0),  32'h5A);
    check("d_chg0", 32'(chg0), 32'hA5);
    check("d_q2",   32'(q2),   32'hA5);
    check("d_chg2", 32'(chg2), 32'h24);

    // T mode, toggling every bit twice
    drive(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    edge_step();
    check("t1_q0",   32'(q0),   32'h5A);
    check("t1_chg0", 32'(chg0), 32'hFF);
    edge_step();
    check("t2_q0",   32'(q0),   32'hA5);
    check("t2_chg0", 32'(chg0), 32'hFF);

    // JK mode from 0F: j=F0 k=3C gives set/toggle on the upper bits, clear on 3:2, hold on 1:0
    drive(1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    edge_step();
    check("ld_q0", 32'(q0), 32'h0F);
    drive(1'b1, 2'b10, 8'hF0, 8'h3C, 1'b0);
    edge_step();
    check("jk_q0",   32'(q0),   32'hF3);
    check("jk_chg0", 32'(chg0), 32'hFC);

    // SR=11 on bit 0 for each policy
    drive(1'b1, 2'b00, 8'h0F, 8'h00, 1'b0);
    edge_step();
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    edge_step();
    check("sr11_q0",   32'(q0),   32'h0F);
    check("sr11_q1",   32'(q1),   32'h0F);
    check("sr11_q2",   32'(q2),   32'h0E);
    check("sr11_chg2", 32'(chg2), 32'h01);
    check("sr11_err0", 32'(e0),   32'h1);
    check("sr11_err2", 32'(e2),   32'h1);
    // Clear with no new error
    drive(1'b0, 2'b11, 8'h01, 8'h01, 1'b1);
    edge_step();
    check("clr_err0", 32'(e0), 32'h0);
    check("clr_q2",   32'(q2), 32'h0E);
    // A set in the same cycle as a clear wins
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b1);
    edge_step();
    check("setwin_err1", 32'(e1), 32'h1);
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
    edge_step();
    check("clr2_err1", 32'(e1), 32'h0);
    // Plain SR with no conflict
    drive(1'b1, 2'b11, 8'hF0, 8'h0F, 1'b0);
    edge_step();
    check("sr_q0",   32'(q0), 32'hF0);
    check("sr_q2",   32'(q2), 32'hF0);
    check("sr_err0", 32'(e0), 32'h0);

    // en=0 with sr_err set: everything holds
    drive(1'b1, 2'b11, 8'h01, 8'h01, 1'b0);
    edge_step();
    check("pre_q1",   32'(q1), 32'hF1);
    check("pre_err0", 32'(e0), 32'h1);
    drive(1'b0, 2'b00, 8'hFF, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      edge_step();
      check("hold_q0",   32'(q0),   32'hF0);
      check("hold_chg0", 32'(chg0), 32'h00);
      check("hold_err0", 32'(e0),   32'h1);
    end

    // Asynchronous reset in the middle of T toggling
    drive(1'b1, 2'b01, 8'hFF, 8'h00, 1'b0);
    edge_step();
    check("tt_q0", 32'(q0), 32'h0F);
    #1 rst = 1'b1;
    #1;
    check("arst_q0",   32'(q0),   32'h00);
    check("arst_q2",   32'(q2),   32'h81);
    check("arst_chg0", 32'(chg0), 32'h00);
    check("arst_err0", 32'(e0),   32'h0);
    #1 rst = 1'b0;
    drive(1'b1, 2'b01, 8'h0F, 8'h00, 1'b0);
    edge_step();
    check("post_q0",   32'(q0),   32'h0F);
    check("post_q2",   32'(q2),   32'h8E);
    check("post_chg2", 32'(chg2), 32'h0F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
